dcp_rd_cmd_xbar: RTL and testbench

//  Parametrised NUM_IN x NUM_OUT read-command crossbar over Decoupled channels; successor to the fixed 16x16 switch/route tree.
//  Per-output round-robin arbitration, per-output command FIFO, optional source-tag rewrite of Dst, illegal-Dst drop with error count.

---
 rtl/dcp_rd_cmd_xbar_pkg.sv | 30 +++
 rtl/dcp_rd_cmd_xbar_if.sv | 14 +
 rtl/dcp_rd_cmd_xbar_arb.sv | 42 ++++
 rtl/dcp_rd_cmd_xbar.sv | 131 +++++++++++++
 tb/tb_dcp_rd_cmd_xbar.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dcp_rd_cmd_xbar_pkg.sv
// Shared constants and types for the read-command crossbar.
package dcp_xbar_pkg;

  // Address length of the packet buffer; payload carries it plus 9 control bits.
  localparam int ADDR_LENTH     = 23;

  localparam int DEF_NUM_IN     = 16;
  localparam int DEF_NUM_OUT    = 16;
  localparam int DEF_DW         = ADDR_LENTH + 9;
  localparam int DEF_AW         = 5;
  localparam int DEF_FIFO_DEPTH = 4;

  localparam int IN_IW          = $clog2(DEF_NUM_IN);
  localparam int FIFO_AW        = $clog2(DEF_FIFO_DEPTH);
  localparam int DROP_CW        = 16;

  typedef struct packed {
    logic [DEF_DW-1:0] Pld;
    logic [DEF_AW-1:0] Dst;
  } xbar_ent_t;

  // Saturating add for the drop counter.
  function automatic logic [DROP_CW-1:0] satAdd(input logic [DROP_CW-1:0] a,
                                                input logic [DROP_CW-1:0] b);
    logic [DROP_CW:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[DROP_CW] ? {DROP_CW{1'b1}} : sum[DROP_CW-1:0];
  endfunction

endpackage

// File: rtl/dcp_rd_cmd_xbar_if.sv
// Bundle of N Decoupled read-command channels (one bit / one lane per channel).
interface dcp_rd_cmd_xbar_if #(
  parameter int N  = 16,
  parameter int DW = 32,
  parameter int AW = 5
);
  logic [N-1:0]         Vld;
  logic [N-1:0]         Rdy;
  logic [N-1:0][DW-1:0] Pld;
  logic [N-1:0][AW-1:0] Dst;

  modport master (output Vld, Pld, Dst, input  Rdy);
  modport slave  (input  Vld, Pld, Dst, output Rdy);
endinterface

// File: rtl/dcp_rd_cmd_xbar_arb.sv
// Round-robin arbiter: first requester at or after the pointer wins;
// the pointer moves past the winner only when the grant is taken.
module dcp_rr_arbiter #(
  parameter int N = 16
) (
  input  logic         iClk,
  input  logic         iRst_n,
  input  logic [N-1:0] iReq,
  input  logic         iEn,
  input  logic         iAck,
  output logic [N-1:0] oGnt
);
  localparam int IW = $clog2(N);

  logic [IW-1:0] ptr;
  logic [IW-1:0] winIdx;
  logic          found;
  logic [IW:0]   idx;

  // Scan requesters starting at the pointer, wrapping mod N
  always_comb begin
    oGnt   = '0;
    winIdx = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < N; k++) begin
      idx = {1'b0, ptr} + (IW+1)'(k);
      if (idx >= (IW+1)'(N)) idx = idx - (IW+1)'(N);
      if (!found && iReq[idx[IW-1:0]]) begin
        found  = 1'b1;
        winIdx = idx[IW-1:0];
      end
    end
    if (iEn && found) oGnt[winIdx] = 1'b1;
  end

  // Advance the pointer one past the winner on a taken grant
  always_ff @(posedge iClk) begin
    if (!iRst_n)   ptr <= '0;
    else if (iAck) ptr <= (winIdx == IW'(N-1)) ? '0 : winIdx + 1'b1;
  end
endmodule

// File: rtl/dcp_rd_cmd_xbar.sv
// NUM_IN x NUM_OUT read-command crossbar: per-output RR arbiter and command
// FIFO, optional source-index tagging of Dst, illegal-Dst drop with counter.
module dcp_rd_cmd_xbar
  import dcp_xbar_pkg::*;
#(
  parameter int NUM_IN     = DEF_NUM_IN,
  parameter int NUM_OUT    = DEF_NUM_OUT,
  parameter int DW         = DEF_DW,
  parameter int AW         = DEF_AW,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int SRC_TAG    = 0
) (
  input  logic               iClk,
  input  logic               iRst_n,
  dcp_rd_cmd_xbar_if.slave   iRdCmdIn,
  dcp_rd_cmd_xbar_if.master  oRdCmdOut,
  output logic [DROP_CW-1:0] oDropCnt,
  output logic               oErr
);
  localparam int fifoAw = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [DW-1:0] Pld;
    logic [AW-1:0] Dst;
  } ent_t;

  logic [NUM_IN-1:0]                illegal;
  logic [NUM_IN-1:0]                inRdy;
  logic [NUM_OUT-1:0][NUM_IN-1:0]   req;
  logic [NUM_OUT-1:0][NUM_IN-1:0]   gnt;
  logic [NUM_OUT-1:0]               outVld;
  logic [NUM_OUT-1:0][DW-1:0]       outPld;
  logic [NUM_OUT-1:0][AW-1:0]       outDst;
  logic [DROP_CW-1:0]               dropNow;

  // Decode each input's Dst into per-output request columns
  always_comb begin
    illegal = '0;
    req     = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      illegal[i] = (int'(iRdCmdIn.Dst[i]) >= NUM_OUT);
      for (int o = 0; o < NUM_OUT; o++)
        req[o][i] = iRdCmdIn.Vld[i] && (iRdCmdIn.Dst[i] == AW'(o));
    end
  end

  // Input ready: granted by its output's arbiter, or swallowed as illegal
  always_comb begin
    inRdy = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      inRdy[i] = iRst_n && illegal[i];
      for (int o = 0; o < NUM_OUT; o++) inRdy[i] = inRdy[i] | gnt[o][i];
    end
  end
  assign iRdCmdIn.Rdy = inRdy;

  // Number of illegal-Dst handshakes this cycle
  always_comb begin
    dropNow = '0;
    for (int i = 0; i < NUM_IN; i++)
      dropNow = dropNow + DROP_CW'(iRdCmdIn.Vld[i] && illegal[i]);
  end

  // Saturating drop counter and sticky error flag
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      oDropCnt <= '0;
      oErr     <= 1'b0;
    end else if (dropNow != '0) begin
      oDropCnt <= satAdd(oDropCnt, dropNow);
      oErr     <= 1'b1;
    end
  end

  for (genvar o = 0; o < NUM_OUT; o++) begin : gOut
    logic [fifoAw:0] wrPtr, rdPtr;
    logic            full, empty, push, pop;
    ent_t            pushEnt;
    ent_t            mem [FIFO_DEPTH];

    assign empty = (wrPtr == rdPtr);
    assign full  = (wrPtr[fifoAw] != rdPtr[fifoAw]) &&
                   (wrPtr[fifoAw-1:0] == rdPtr[fifoAw-1:0]);
    assign push  = |gnt[o];
    assign pop   = outVld[o] && oRdCmdOut.Rdy[o];

    // Grant only with space available now; a same-cycle pop gives no credit,
    // which keeps output Rdy out of the input Rdy path.
    dcp_rr_arbiter #(.N(NUM_IN)) uArb (
      .iClk   (iClk),
      .iRst_n (iRst_n),
      .iReq   (req[o]),
      .iEn    (iRst_n && !full),
      .iAck   (push),
      .oGnt   (gnt[o])
    );

    // Pick the granted input's command; the grant is one-hot
    always_comb begin
      pushEnt = '0;
      for (int i = 0; i < NUM_IN; i++) begin
        if (gnt[o][i]) begin
          pushEnt.Pld = iRdCmdIn.Pld[i];
          pushEnt.Dst = (SRC_TAG != 0) ? AW'(i) : iRdCmdIn.Dst[i];
        end
      end
    end

    // Command FIFO; pointers carry an extra wrap bit for full/empty
    always_ff @(posedge iClk) begin
      if (!iRst_n) begin
        wrPtr <= '0;
        rdPtr <= '0;
      end else begin
        if (push) begin
          mem[wrPtr[fifoAw-1:0]] <= pushEnt;
          wrPtr <= wrPtr + 1'b1;
        end
        if (pop) rdPtr <= rdPtr + 1'b1;
      end
    end

    assign outVld[o] = !empty;
    assign outPld[o] = mem[rdPtr[fifoAw-1:0]].Pld;
    assign outDst[o] = mem[rdPtr[fifoAw-1:0]].Dst;
  end

  assign oRdCmdOut.Vld = outVld;
  assign oRdCmdOut.Pld = outPld;
  assign oRdCmdOut.Dst = outDst;
endmodule

// File: tb/tb_dcp_rd_cmd_xbar.sv
// Bench for dcp_rd_cmd_xbar: two DUTs (SRC_TAG=0 and 1) share one stimulus;
// a scoreboard checks every output pop, directed checks cover the corner cases.
module tb_dcp_rd_cmd_xbar;
  localparam int NI = 16, NO = 16, DW = 32, AW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dcp_rd_cmd_xbar_if #(.N(NI), .DW(DW), .AW(AW)) in0(), out0(), in1(), out1();
  logic [15:0] drop0, drop1;
  logic        err0, err1;

  assign in1.Vld  = in0.Vld;
  assign in1.Pld  = in0.Pld;
  assign in1.Dst  = in0.Dst;
  assign out1.Rdy = out0.Rdy;

  dcp_rd_cmd_xbar #(.NUM_IN(NI), .NUM_OUT(NO), .DW(DW), .AW(AW), .FIFO_DEPTH(4), .SRC_TAG(0)) u0 (
    .iClk(clk), .iRst_n(rst_n), .iRdCmdIn(in0), .oRdCmdOut(out0), .oDropCnt(drop0), .oErr(err0));
  dcp_rd_cmd_xbar #(.NUM_IN(NI), .NUM_OUT(NO), .DW(DW), .AW(AW), .FIFO_DEPTH(4), .SRC_TAG(1)) u1 (
    .iClk(clk), .iRst_n(rst_n), .iRdCmdIn(in1), .oRdCmdOut(out1), .oDropCnt(drop1), .oErr(err1));

  typedef struct {
    logic [31:0] pld;
    logic [4:0]  dst;
    logic [4:0]  src;
  } sbEnt_t;

  sbEnt_t      sbq [NO][$];
  int          nChecks = 0;
  int          nFail   = 0;
  logic [31:0] tagCnt  = 32'h5000_0000;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard: pop/compare on output handshakes, push on legal input handshakes
  always @(negedge clk) begin
    sbEnt_t e;
    if (!rst_n) begin
      for (int o = 0; o < NO; o++) sbq[o].delete();
    end else begin
      for (int o = 0; o < NO; o++) begin
        if (out0.Vld[o] && out0.Rdy[o]) begin
          if (sbq[o].size() == 0) begin
            nChecks++;
            nFail++;
            $display("FAIL sb_unexpected out%0d: got Pld %0h, expected no output", o, out0.Pld[o]);
          end else begin
            e = sbq[o].pop_front();
            chk($sformatf("sb_pld0 out%0d", o), 64'(out0.Pld[o]), 64'(e.pld));
            chk($sformatf("sb_dst0 out%0d", o), 64'(out0.Dst[o]), 64'(e.dst));
            chk($sformatf("sb_vld1 out%0d", o), 64'(out1.Vld[o]), 64'd1);
            chk($sformatf("sb_pld1 out%0d", o), 64'(out1.Pld[o]), 64'(e.pld));
            chk($sformatf("sb_dst1 out%0d", o), 64'(out1.Dst[o]), 64'(e.src));
          end
        end
      end
      for (int i = 0; i < NI; i++) begin
        if (in0.Vld[i] && in0.Rdy[i] && (in0.Dst[i] < 5'(NO))) begin
          e.pld = in0.Pld[i];
          e.dst = in0.Dst[i];
          e.src = 5'(i);
          sbq[in0.Dst[i]].push_back(e);
        end
      end
    end
  end

  task automatic nextCyc();
    @(posedge clk);
    #1;
  endtask

  task automatic setIn(input int i, input logic v, input logic [4:0] d);
    in0.Vld[i] = v;
    in0.Dst[i] = d;
    in0.Pld[i] = tagCnt;
    tagCnt     = tagCnt + 1;
  endtask

  task automatic doReset();
    nextCyc();
    rst_n    = 1'b0;
    in0.Vld  = '0;
    out0.Rdy = '1;
    repeat (2) nextCyc();
    rst_n = 1'b1;
  endtask

  task automatic drain(input string nm);
    int tot;
    in0.Vld  = '0;
    out0.Rdy = '1;
    tot = 0;
    for (int c = 0; c < 40; c++) begin
      nextCyc();
      tot = 0;
      for (int o = 0; o < NO; o++) tot += sbq[o].size();
      if (tot == 0) break;
    end
    chk({nm, "_sb_empty"}, 64'(tot), 64'd0);
    @(negedge clk);
    chk({nm, "_out_idle"}, 64'(out0.Vld), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int ord [6];
    logic [31:0] headPld;
    ord = '{0, 3, 7, 0, 3, 7};
    in0.Vld = '0; in0.Pld = '0; in0.Dst = '0; out0.Rdy = '1;

    // T1: reset held with every input valid
    rst_n = 1'b0;
    for (int i = 0; i < NI; i++) setIn(i, 1'b1, 5'(i));
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t1_rst_out_vld", 64'(out0.Vld), 64'd0);
    chk("t1_rst_in_rdy", 64'(in0.Rdy), 64'd0);
    chk("t1_rst_drop", 64'(drop0), 64'd0);
    chk("t1_rst_err", 64'(err0), 64'd0);
    nextCyc();
    rst_n = 1'b1;
    @(negedge clk);
    chk("t1_release_rdy", 64'(in0.Rdy), 64'hFFFF);
    chk("t1_release_out_vld", 64'(out0.Vld), 64'd0);
    nextCyc();
    in0.Vld = '0;
    @(negedge clk);
    chk("t1_out_vld", 64'(out0.Vld), 64'hFFFF);
    drain("t1");

    // T2: round-robin among inputs 0,3,7 on output 2
    doReset();
    for (int k = 0; k < 6; k++) begin
      setIn(0, 1'b1, 5'd2); setIn(3, 1'b1, 5'd2); setIn(7, 1'b1, 5'd2);
      @(negedge clk);
      chk($sformatf("t2_grant%0d", k), 64'(in0.Rdy), 64'(16'(1) << ord[k]));
      chk($sformatf("t2_out_vld%0d", k), 64'(out0.Vld[2]), (k == 0) ? 64'd0 : 64'd1);
      nextCyc();
    end
    in0.Vld = '0;
    @(negedge clk);
    chk("t2_out_vld_last", 64'(out0.Vld[2]), 64'd1);
    drain("t2");

    // T3: backpressure on output 5, FIFO of 4
    doReset();
    out0.Rdy[5] = 1'b0;
    headPld = '0;
    for (int k = 0; k < 8; k++) begin
      setIn(1, 1'b1, 5'd5);
      if (k == 0) headPld = in0.Pld[1];
      @(negedge clk);
      chk($sformatf("t3_rdy%0d", k), 64'(in0.Rdy[1]), (k < 4) ? 64'd1 : 64'd0);
      chk($sformatf("t3_out_vld%0d", k), 64'(out0.Vld[5]), (k == 0) ? 64'd0 : 64'd1);
      if (k > 0) chk($sformatf("t3_head_stable%0d", k), 64'(out0.Pld[5]), 64'(headPld));
      nextCyc();
    end
    out0.Rdy[5] = 1'b1;
    setIn(1, 1'b1, 5'd5);
    @(negedge clk);
    chk("t3_no_same_cycle_credit", 64'(in0.Rdy[1]), 64'd0);
    nextCyc();
    setIn(1, 1'b1, 5'd5);
    @(negedge clk);
    chk("t3_resume", 64'(in0.Rdy[1]), 64'd1);
    nextCyc();
    drain("t3");

    // T4: illegal Dst, drop count and saturation
    doReset();
    setIn(2, 1'b1, 5'd20);
    setIn(9, 1'b1, 5'd20);
    @(negedge clk);
    chk("t4_rdy", 64'(in0.Rdy), 64'h0204);
    chk("t4_err_before", 64'(err0), 64'd0);
    nextCyc();
    in0.Vld = '0;
    @(negedge clk);
    chk("t4_drop", 64'(drop0), 64'd2);
    chk("t4_err", 64'(err0), 64'd1);
    chk("t4_drop_tag", 64'(drop1), 64'd2);
    chk("t4_err_tag", 64'(err1), 64'd1);
    chk("t4_no_out", 64'(out0.Vld), 64'd0);
    nextCyc();
    for (int i = 0; i < NI; i++) setIn(i, 1'b1, 5'd31);
    repeat (4095) @(posedge clk);
    @(negedge clk);
    chk("t4_drop_fff2", 64'(drop0), 64'hFFF2);
    @(negedge clk);
    chk("t4_drop_clamp", 64'(drop0), 64'hFFFF);
    @(negedge clk);
    chk("t4_drop_hold", 64'(drop0), 64'hFFFF);
    chk("t4_err_sticky", 64'(err0), 64'd1);
    chk("t4_no_out_sat", 64'(out0.Vld), 64'd0);
    nextCyc();
    in0.Vld = '0;
    drain("t4");

    // T5: source tagging (DUT1) vs pass-through Dst (DUT0)
    doReset();
    @(negedge clk);
    chk("t5_err_cleared", 64'(err0), 64'd0);
    chk("t5_drop_cleared", 64'(drop0), 64'd0);
    nextCyc();
    out0.Rdy[4] = 1'b0;
    setIn(11, 1'b1, 5'd4);
    in0.Pld[11] = 32'hABC;
    @(negedge clk);
    chk("t5_rdy", 64'(in0.Rdy[11]), 64'd1);
    nextCyc();
    in0.Vld = '0;
    @(negedge clk);
    chk("t5_vld", 64'(out0.Vld[4]), 64'd1);
    chk("t5_pld0", 64'(out0.Pld[4]), 64'hABC);
    chk("t5_dst0", 64'(out0.Dst[4]), 64'd4);
    chk("t5_pld1", 64'(out1.Pld[4]), 64'hABC);
    chk("t5_dst1", 64'(out1.Dst[4]), 64'd11);
    nextCyc();
    drain("t5");

    // T6: all inputs to distinct outputs, random valid and output ready
    doReset();
    for (int c = 0; c < 1000; c++) begin
      for (int i = 0; i < NI; i++) setIn(i, 1'($urandom_range(0, 1)), 5'((i + 5) % NO));
      out0.Rdy = 16'($urandom);
      nextCyc();
    end
    drain("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end
endmodule
